// File: rtl/hanoi_move_sequencer.sv
// Hanoi move sequencer: launches the tower, checks each move it reports
// against a per-disk position model, and buffers legal moves in a small
// FIFO that a slow consumer drains through a valid/ready handshake.
module hanoi_move_sequencer #(
  parameter int DISKS        = 5,
  parameter int FIFO_DEPTH   = 4,
  parameter int START_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  output logic             tower_start,
  input  logic             mv_strobe,
  input  logic [1:0]       mv_from,
  input  logic [1:0]       mv_to,
  input  logic             tower_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_from,
  output logic [1:0]       out_to,
  output logic [DISKS:0]   move_count,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [2:0]       err_code
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int IW = (DISKS > 1) ? $clog2(DISKS) : 1;
  localparam int SW = $clog2(START_CYCLES + 1);
  localparam logic [DISKS:0]  TOTAL      = (DISKS + 1)'((1 << DISKS) - 1);
  localparam logic [AW:0]     FULL_LVL   = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]     ONE_LVL    = (AW + 1)'(1);
  localparam logic [SW-1:0]   START_LAST = SW'(START_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [SW-1:0]   start_cnt;

  logic [1:0]      pos [DISKS];
  logic [1:0]      pos_after [DISKS];
  logic            src_found;
  logic            dst_found;
  logic [IW-1:0]   src_top;
  logic [IW-1:0]   dst_top;
  logic            code_bad;
  logic            stack_bad;
  logic            fifo_block;
  logic            count_cap;
  logic            move_ok;
  logic            all_home;
  logic [DISKS:0]  count_after;

  logic [3:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     fifo_count;
  logic            fifo_full;
  logic            pop;

  logic            launch;
  logic            flush;
  logic            err_set;
  logic [2:0]      err_val;

  assign out_valid   = (fifo_count != '0);
  assign fifo_full   = (fifo_count == FULL_LVL);
  assign pop         = out_valid && out_ready;
  assign out_from    = out_valid ? mem[rd_ptr][3:2] : 2'd0;
  assign out_to      = out_valid ? mem[rd_ptr][1:0] : 2'd0;
  assign tower_start = (state == S_START);
  assign busy        = (state == S_START) || (state == S_RUN) || (state == S_DRAIN);
  assign done        = (state == S_DONE);
  assign error       = (state == S_ERROR);

  // Move legality: find peg tops, classify the strobed move, and preview the disk positions after it.
  always_comb begin
    src_found = 1'b0;
    src_top   = '0;
    dst_found = 1'b0;
    dst_top   = '0;
    for (int i = DISKS - 1; i >= 0; i--) begin
      if (pos[i] == mv_from) begin
        src_found = 1'b1;
        src_top   = IW'(i);
      end
      if (pos[i] == mv_to) begin
        dst_found = 1'b1;
        dst_top   = IW'(i);
      end
    end
    code_bad    = (mv_from == 2'd0) || (mv_to == 2'd0) || (mv_from == mv_to);
    stack_bad   = !src_found || (dst_found && (dst_top < src_top));
    fifo_block  = fifo_full && !pop;
    count_cap   = (move_count == TOTAL);
    move_ok     = (state == S_RUN) && mv_strobe && !code_bad && !stack_bad &&
                  !fifo_block && !count_cap;
    count_after = move_count + (DISKS + 1)'(move_ok);
    for (int i = 0; i < DISKS; i++) begin
      pos_after[i] = (move_ok && (IW'(i) == src_top)) ? mv_to : pos[i];
    end
    all_home = (pos_after[0] != 2'd1);
    for (int i = 1; i < DISKS; i++) begin
      if (pos_after[i] != pos_after[0]) begin
        all_home = 1'b0;
      end
    end
  end

  // Next-state and control decode; move errors outrank the completion check.
  always_comb begin
    next_state = state;
    launch     = 1'b0;
    flush      = 1'b0;
    err_set    = 1'b0;
    err_val    = 3'd0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (go) begin
          next_state = S_START;
          launch     = 1'b1;
          flush      = 1'b1;
        end
      end
      S_START: begin
        if (start_cnt == START_LAST) begin
          next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (mv_strobe) begin
          if (code_bad) begin
            err_set = 1'b1;
            err_val = 3'd1;
          end else if (stack_bad) begin
            err_set = 1'b1;
            err_val = 3'd2;
          end else if (fifo_block) begin
            err_set = 1'b1;
            err_val = 3'd3;
          end else if (count_cap) begin
            err_set = 1'b1;
            err_val = 3'd4;
          end
        end
        if (!err_set && tower_done) begin
          if ((count_after == TOTAL) && all_home) begin
            next_state = S_DRAIN;
          end else begin
            err_set = 1'b1;
            err_val = 3'd4;
          end
        end
        if (err_set) begin
          next_state = S_ERROR;
          flush      = 1'b1;
        end
      end
      S_DRAIN: begin
        if ((fifo_count == '0) || ((fifo_count == ONE_LVL) && pop)) begin
          next_state = S_DONE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Counts how long tower_start has been held in START.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_cnt <= '0;
    end else if (launch) begin
      start_cnt <= '0;
    end else if ((state == S_START) && (start_cnt != START_LAST)) begin
      start_cnt <= start_cnt + SW'(1);
    end
  end

  // Disk position model and accepted-move counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      move_count <= '0;
      for (int i = 0; i < DISKS; i++) begin
        pos[i] <= 2'd1;
      end
    end else if (launch) begin
      move_count <= '0;
      for (int i = 0; i < DISKS; i++) begin
        pos[i] <= 2'd1;
      end
    end else if (move_ok) begin
      move_count <= count_after;
      for (int i = 0; i < DISKS; i++) begin
        pos[i] <= pos_after[i];
      end
    end
  end

  // Error code is captured on entry to ERROR and cleared by a new launch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_code <= 3'd0;
    end else if (launch) begin
      err_code <= 3'd0;
    end else if (err_set) begin
      err_code <= err_val;
    end
  end

  // FIFO pointers and occupancy; a flush empties it regardless of traffic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (move_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({move_ok, pop})
        2'b10:   fifo_count <= fifo_count + ONE_LVL;
        2'b01:   fifo_count <= fifo_count - ONE_LVL;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage; the head is only visible while out_valid is high.
  always_ff @(posedge clk) begin
    if (move_ok) begin
      mem[wr_ptr] <= {mv_from, mv_to};
    end
  end

endmodule

// File: tb/tb_hanoi_move_sequencer.sv
// Bench for hanoi_move_sequencer: directed scenarios plus randomized runs,
// all checked against a stack-of-pegs reference model.
module tb_hanoi_move_sequencer;

  localparam int DISKS        = 3;
  localparam int FIFO_DEPTH   = 4;
  localparam int START_CYCLES = 2;
  localparam int TOTAL        = (1 << DISKS) - 1;

  logic             clk;
  logic             reset;
  logic             go;
  logic             tower_start;
  logic             mv_strobe;
  logic [1:0]       mv_from;
  logic [1:0]       mv_to;
  logic             tower_done;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_from;
  logic [1:0]       out_to;
  logic [DISKS:0]   move_count;
  logic             busy;
  logic             done;
  logic             error;
  logic [2:0]       err_code;

  int n_assert = 0;
  int n_fail   = 0;

  typedef enum {M_IDLE, M_START, M_RUN, M_DRAIN, M_DONE, M_ERROR} mphase_t;
  mphase_t     m_ph;
  int          m_start_left;
  int          m_count;
  int          m_err;
  int          pegs [3][$];
  logic [3:0]  mq [$];

  int sol_from [7];
  int sol_to   [7];

  hanoi_move_sequencer #(
    .DISKS(DISKS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .START_CYCLES(START_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .go(go),
    .tower_start(tower_start),
    .mv_strobe(mv_strobe),
    .mv_from(mv_from),
    .mv_to(mv_to),
    .tower_done(tower_done),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_from(out_from),
    .out_to(out_to),
    .move_count(move_count),
    .busy(busy),
    .done(done),
    .error(error),
    .err_code(err_code)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global watchdog.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_ph         = M_IDLE;
    m_start_left = 0;
    m_count      = 0;
    m_err        = 0;
    mq.delete();
    for (int p = 0; p < 3; p++) pegs[p].delete();
    for (int d = DISKS - 1; d >= 0; d--) pegs[0].push_back(d);
  endtask

  // One clock of the reference model, using pre-edge state and inputs.
  task automatic modelStep(input logic g, input logic s, input logic [1:0] f, input logic [1:0] t,
                           input logic td, input logic r);
    bit pop_now, flushed, pushed, was_drain;
    int fi, ti, errc, d;
    pop_now   = (mq.size() != 0) && r;
    flushed   = 0;
    pushed    = 0;
    was_drain = (m_ph == M_DRAIN);
    fi        = int'(f);
    ti        = int'(t);
    errc      = 0;
    case (m_ph)
      M_IDLE, M_DONE, M_ERROR: begin
        if (g) begin
          modelReset();
          m_ph         = M_START;
          m_start_left = START_CYCLES;
          flushed      = 1;
        end
      end
      M_START: begin
        m_start_left--;
        if (m_start_left == 0) m_ph = M_RUN;
      end
      M_RUN: begin
        if (s) begin
          if (fi == 0 || ti == 0 || fi == ti) errc = 1;
          else if (pegs[fi-1].size() == 0) errc = 2;
          else if (pegs[ti-1].size() != 0 &&
                   pegs[ti-1][pegs[ti-1].size()-1] < pegs[fi-1][pegs[fi-1].size()-1]) errc = 2;
          else if (mq.size() == FIFO_DEPTH && !pop_now) errc = 3;
          else if (m_count == TOTAL) errc = 4;
          else begin
            d = pegs[fi-1].pop_back();
            pegs[ti-1].push_back(d);
            m_count++;
            pushed = 1;
          end
        end
        if (errc == 0 && td) begin
          if (m_count == TOTAL && (pegs[1].size() == DISKS || pegs[2].size() == DISKS))
            m_ph = M_DRAIN;
          else errc = 4;
        end
        if (errc != 0) begin
          m_ph    = M_ERROR;
          m_err   = errc;
          flushed = 1;
        end
      end
      default: ;
    endcase
    if (flushed) mq.delete();
    else begin
      if (pop_now) void'(mq.pop_front());
      if (pushed) mq.push_back({f, t});
    end
    if (was_drain && mq.size() == 0) m_ph = M_DONE;
  endtask

  task automatic checkAll();
    checkOutput("tower_start", {7'b0, tower_start}, {7'b0, (m_ph == M_START)});
    checkOutput("busy", {7'b0, busy}, {7'b0, (m_ph == M_START || m_ph == M_RUN || m_ph == M_DRAIN)});
    checkOutput("done", {7'b0, done}, {7'b0, (m_ph == M_DONE)});
    checkOutput("error", {7'b0, error}, {7'b0, (m_ph == M_ERROR)});
    checkOutput("err_code", {5'b0, err_code}, 8'(m_err));
    checkOutput("move_count", {4'b0, move_count}, 8'(m_count));
    checkOutput("out_valid", {7'b0, out_valid}, {7'b0, (mq.size() != 0)});
    if (mq.size() != 0) begin
      checkOutput("out_from", {6'b0, out_from}, {6'b0, mq[0][3:2]});
      checkOutput("out_to", {6'b0, out_to}, {6'b0, mq[0][1:0]});
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_tower_start"}, {7'b0, tower_start}, 8'd0);
    checkOutput({tag, "_out_valid"}, {7'b0, out_valid}, 8'd0);
    checkOutput({tag, "_out_from"}, {6'b0, out_from}, 8'd0);
    checkOutput({tag, "_out_to"}, {6'b0, out_to}, 8'd0);
    checkOutput({tag, "_move_count"}, {4'b0, move_count}, 8'd0);
    checkOutput({tag, "_busy"}, {7'b0, busy}, 8'd0);
    checkOutput({tag, "_done"}, {7'b0, done}, 8'd0);
    checkOutput({tag, "_error"}, {7'b0, error}, 8'd0);
    checkOutput({tag, "_err_code"}, {5'b0, err_code}, 8'd0);
  endtask

  // Drive one cycle of inputs, advance model and DUT, then compare.
  task automatic applyStimulus(input logic g, input logic s, input logic [1:0] f, input logic [1:0] t,
                               input logic td, input logic r);
    go         = g;
    mv_strobe  = s;
    mv_from    = f;
    mv_to      = t;
    tower_done = td;
    out_ready  = r;
    modelStep(g, s, f, t, td, r);
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic doLaunch(input logic r);
    applyStimulus(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, r);
    repeat (START_CYCLES) applyStimulus(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, r);
  endtask

  task automatic solveMoves(input int first, input int last, input logic r);
    for (int i = first; i <= last; i++)
      applyStimulus(1'b0, 1'b1, 2'(sol_from[i]), 2'(sol_to[i]), 1'b0, r);
  endtask

  task automatic finishRun(input string tag);
    applyStimulus(1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1);
    for (int k = 0; k < 20 && m_ph == M_DRAIN; k++)
      applyStimulus(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    checkOutput({tag, "_done"}, {7'b0, done}, 8'd1);
    checkOutput({tag, "_count"}, {4'b0, move_count}, 8'(TOTAL));
  endtask

  int  idx;
  int  guard;
  logic rr;

  initial begin
    sol_from = '{1, 1, 3, 1, 2, 2, 1};
    sol_to   = '{3, 2, 2, 3, 1, 3, 3};
    go = 0; mv_strobe = 0; mv_from = 0; mv_to = 0; tower_done = 0; out_ready = 0;
    modelReset();

    $display("[TB] reset");
    reset = 1'b1;
    #1;
    checkAllZero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkAll();

    $display("[TB] full solve");
    doLaunch(1'b1);
    solveMoves(0, 6, 1'b1);
    finishRun("solve1");

    $display("[TB] restart from done, illegal stacking");
    doLaunch(1'b1);
    solveMoves(0, 0, 1'b1);
    applyStimulus(1'b0, 1'b1, 2'd1, 2'd3, 1'b0, 1'b1);
    checkOutput("stack_err_code", {5'b0, err_code}, 8'd2);
    checkOutput("stack_count", {4'b0, move_count}, 8'd1);

    $display("[TB] bad peg code");
    doLaunch(1'b1);
    applyStimulus(1'b0, 1'b1, 2'd0, 2'd2, 1'b0, 1'b1);
    checkOutput("code_err_code", {5'b0, err_code}, 8'd1);

    $display("[TB] backpressure overflow");
    doLaunch(1'b0);
    solveMoves(0, 3, 1'b0);
    checkOutput("bp_full_valid", {7'b0, out_valid}, 8'd1);
    solveMoves(4, 4, 1'b0);
    checkOutput("bp_err_code", {5'b0, err_code}, 8'd3);

    $display("[TB] backpressure with pop");
    doLaunch(1'b0);
    solveMoves(0, 3, 1'b0);
    solveMoves(4, 6, 1'b1);
    checkOutput("bp_pop_error", {7'b0, error}, 8'd0);
    finishRun("bp_pop");

    $display("[TB] early completion");
    doLaunch(1'b1);
    solveMoves(0, 4, 1'b1);
    applyStimulus(1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1);
    checkOutput("early_err_code", {5'b0, err_code}, 8'd4);
    checkOutput("early_done", {7'b0, done}, 8'd0);

    $display("[TB] async reset mid-run");
    doLaunch(1'b0);
    solveMoves(0, 2, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    checkAllZero("async");
    modelReset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    doLaunch(1'b1);
    solveMoves(0, 6, 1'b1);
    finishRun("solve2");

    $display("[TB] randomized runs");
    for (int run = 0; run < 12; run++) begin
      doLaunch(1'($urandom_range(0, 1)));
      idx   = 0;
      guard = 0;
      while (idx < 7 && guard < 60 && m_ph == M_RUN) begin
        guard++;
        rr = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1) == 1) begin
          if ($urandom_range(0, 15) == 0) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'b1, 2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)), 1'b0, rr);
          end else begin
            applyStimulus(1'b0, 1'b1, 2'(sol_from[idx]), 2'(sol_to[idx]),
                          (idx == 6) && ($urandom_range(0, 1) == 1), rr);
            idx++;
          end
        end else begin
          applyStimulus(1'($urandom_range(0, 7) == 0), 1'b0, 2'd0, 2'd0,
                        ($urandom_range(0, 31) == 0), rr);
        end
      end
      if (m_ph == M_RUN) applyStimulus(1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1);
      for (int k = 0; k < 20 && m_ph == M_DRAIN; k++)
        applyStimulus(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
      checkOutput("rand_run_end", {7'b0, (done | error)}, 8'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
